// File: rtl/pulse_tx_pkg.sv
// rtl/pulse_tx_pkg.sv - shared state encoding and width defaults for pulse generators
package pulse_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_GAP_W = 4;

endpackage

// File: rtl/pulse_train_tx_if.sv
// rtl/pulse_train_tx_if.sv - control and pulse-line signals of the pulse train transmitter
interface pulse_train_tx_if
    import pulse_tx_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
);
    logic             start;
    logic [CNT_W-1:0] count;
    logic [GAP_W-1:0] gap;
    logic             x_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;

    modport master (
        output start, count, gap,
        input  x_out, busy, done, pulses_left
    );

    modport slave (
        input  start, count, gap,
        output x_out, busy, done, pulses_left
    );
endinterface

// File: rtl/pulse_gap_timer.sv
// rtl/pulse_gap_timer.sv - loadable down-counter timing inter-pulse gaps
module pulse_gap_timer
    import pulse_tx_pkg::*;
#(
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] value,
    output logic             expired
);
    logic [GAP_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - GAP_W'(1);
        end
    end

    // Asserted during the final cycle of a loaded interval, so a load of G yields G cycles.
    assign expired = (cnt_q <= GAP_W'(1));

endmodule

// File: rtl/pulse_train_tx.sv
// rtl/pulse_train_tx.sv - Moore transmitter emitting N single-cycle pulses spaced by G idle cycles
module pulse_train_tx
    import pulse_tx_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic            clk,
    input  logic            rst,
    pulse_train_tx_if.slave bus
);
    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [GAP_W-1:0] gap_q;
    logic             tmr_load;
    logic             tmr_expired;

    assign tmr_load = (state_q == PULSE) && (rem_q != '0) && (gap_q != '0);

    pulse_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (gap_q),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            rem_q   <= bus.count - CNT_W'(1);
                            gap_q   <= bus.gap;
                            state_q <= PULSE;
                        end else begin
                            rem_q   <= '0;
                            state_q <= DONE;
                        end
                    end
                end
                PULSE: begin
                    if (rem_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        rem_q   <= rem_q - CNT_W'(1);
                        state_q <= (gap_q == '0) ? PULSE : GAP;
                    end
                end
                GAP: begin
                    if (tmr_expired) begin
                        state_q <= PULSE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.x_out       = (state_q == PULSE);
    assign bus.busy        = (state_q == PULSE) || (state_q == GAP);
    assign bus.done        = (state_q == DONE);
    assign bus.pulses_left = rem_q;

endmodule
